// File: rtl/tx_sequence_modulator.sv
// Transmit-side sequence modulator: plays one of 16 feeder sequences as BPSK
// chips on an fs/4 carrier, one signed 16-bit sample per new-sample trigger.
module tx_sequence_modulator #(
    parameter int SEQ_LEN          = 511,
    parameter int SAMPLES_PER_CHIP = 20,
    parameter int AMPLITUDE        = 16384
) (
    input  logic               ctx_clk,
    input  logic               rtx_rst,
    input  logic               etx_en,
    input  logic               inew_sample_trig,
    input  logic               istart,
    input  logic [3:0]         iseq_select,
    input  logic [15:0]        isequences_bits,
    output logic               onext_bit_req,
    output logic signed [15:0] osample,
    output logic               osample_valid,
    output logic               obusy,
    output logic               odone
);

    localparam int CHIP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int SAMP_W = $clog2(SAMPLES_PER_CHIP);

    localparam logic [CHIP_W-1:0] LAST_CHIP   = CHIP_W'(SEQ_LEN - 1);
    localparam logic [SAMP_W-1:0] LAST_SAMPLE = SAMP_W'(SAMPLES_PER_CHIP - 1);

    localparam logic signed [15:0] AMP_POS = 16'(AMPLITUDE);
    localparam logic signed [15:0] AMP_NEG = 16'(-AMPLITUDE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_TX   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic               rchip_q, rchip_d;
    logic               rchip_next_q, rchip_next_d;
    logic               fetch_pend_q, fetch_pend_d;
    logic [SAMP_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CHIP_W-1:0]  chip_cnt_q, chip_cnt_d;
    logic [1:0]         phase_q, phase_d;
    logic signed [15:0] osample_q, osample_d;
    logic               valid_q, valid_d;
    logic               req;
    logic               run;
    logic [CHIP_W-1:0]  chip_inc;
    logic [15:0]        sel_hit;
    logic               sel_bit;

    assign run      = etx_en & ~rtx_rst;
    assign chip_inc = chip_cnt_q + CHIP_W'(1);

    // One-hot select of the latched sequence's current feeder bit.
    for (genvar gi = 0; gi < 16; gi++) begin : g_sel
        assign sel_hit[gi] = isequences_bits[gi] & (sel_q == 4'(gi));
    end
    assign sel_bit = |sel_hit;

    function automatic logic signed [15:0] modulate(input logic chip, input logic [1:0] p);
        logic signed [15:0] carrier;
        case (p)
            2'd1:    carrier = AMP_POS;
            2'd3:    carrier = AMP_NEG;
            default: carrier = 16'sd0;
        endcase
        return chip ? carrier : -carrier;
    endfunction

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rchip_d      = rchip_q;
        rchip_next_d = rchip_next_q;
        fetch_pend_d = 1'b0;
        sample_cnt_d = sample_cnt_q;
        chip_cnt_d   = chip_cnt_q;
        phase_d      = phase_q;
        osample_d    = osample_q;
        valid_d      = 1'b0;
        req          = 1'b0;

        // Feeder data is valid the cycle after a request.
        if (fetch_pend_q) begin
            rchip_next_d = sel_bit;
        end

        case (state_q)
            ST_IDLE: begin
                osample_d = 16'sd0;
                if (istart) begin
                    sel_d   = iseq_select;
                    req     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rchip_d      = sel_bit;
                req          = 1'b1;
                fetch_pend_d = 1'b1;
                sample_cnt_d = '0;
                chip_cnt_d   = '0;
                phase_d      = 2'd0;
                state_d      = ST_TX;
            end
            ST_TX: begin
                if (inew_sample_trig) begin
                    osample_d = modulate(rchip_q, phase_q);
                    valid_d   = 1'b1;
                    phase_d   = phase_q + 2'd1;
                    if (sample_cnt_q < LAST_SAMPLE) begin
                        sample_cnt_d = sample_cnt_q + SAMP_W'(1);
                    end else if (chip_cnt_q < LAST_CHIP) begin
                        sample_cnt_d = '0;
                        chip_cnt_d   = chip_inc;
                        rchip_d      = rchip_next_q;
                        // The last chip was already prefetched; never read past it.
                        if (chip_inc != LAST_CHIP) begin
                            req          = 1'b1;
                            fetch_pend_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                osample_d = 16'sd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ctx_clk) begin
        if (rtx_rst || !etx_en) begin
            state_q      <= ST_IDLE;
            sel_q        <= 4'd0;
            rchip_q      <= 1'b0;
            rchip_next_q <= 1'b0;
            fetch_pend_q <= 1'b0;
            sample_cnt_q <= '0;
            chip_cnt_q   <= '0;
            phase_q      <= 2'd0;
            osample_q    <= 16'sd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rchip_q      <= rchip_d;
            rchip_next_q <= rchip_next_d;
            fetch_pend_q <= fetch_pend_d;
            sample_cnt_q <= sample_cnt_d;
            chip_cnt_q   <= chip_cnt_d;
            phase_q      <= phase_d;
            osample_q    <= osample_d;
            valid_q      <= valid_d;
        end
    end

    assign onext_bit_req = req & run;
    assign osample       = osample_q;
    assign osample_valid = valid_q;
    assign obusy         = (state_q == ST_LOAD) || (state_q == ST_TX);
    assign odone         = (state_q == ST_DONE);

endmodule

// File: tb/tb_tx_sequence_modulator.sv
// Directed bench: a small-parameter instance for stream-level vectors and a
// default-parameter instance for the full-length, minimum-spacing run.
module tb_tx_sequence_modulator;

    logic        clk = 1'b0;
    logic        rst, en, trig, start_s, start_d;
    logic [3:0]  sel_s, sel_d;
    logic [15:0] bits_s, bits_d;
    logic [15:0] noise, fbits_s, fbits_d;

    logic               req_s, valid_s, busy_s, done_s;
    logic signed [15:0] samp_s;
    logic               req_d, valid_d, busy_d, done_d;
    logic signed [15:0] samp_d;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] MASK_S = 16'h8020;
    localparam logic [15:0] MASK_D = 16'h0200;

    bit pat5  [3] = '{1'b1, 1'b0, 1'b1};
    bit pat15 [3] = '{1'b0, 1'b1, 1'b1};
    int exp_a [12] = '{0, 100, 0, -100, 0, -100, 0, 100, 0, 100, 0, -100};
    int exp_b [12] = '{0, -100, 0, 100, 0, 100, 0, -100, 0, 100, 0, -100};

    always #5 clk = ~clk;

    tx_sequence_modulator #(.SEQ_LEN(3), .SAMPLES_PER_CHIP(4), .AMPLITUDE(100)) dut_s (
        .ctx_clk(clk), .rtx_rst(rst), .etx_en(en), .inew_sample_trig(trig),
        .istart(start_s), .iseq_select(sel_s), .isequences_bits(bits_s),
        .onext_bit_req(req_s), .osample(samp_s), .osample_valid(valid_s),
        .obusy(busy_s), .odone(done_s)
    );

    tx_sequence_modulator dut_d (
        .ctx_clk(clk), .rtx_rst(rst), .etx_en(en), .inew_sample_trig(trig),
        .istart(start_d), .iseq_select(sel_d), .isequences_bits(bits_d),
        .onext_bit_req(req_d), .osample(samp_d), .osample_valid(valid_d),
        .obusy(busy_d), .odone(done_d)
    );

    function automatic bit pat_big(input int k);
        return bit'(((k * 13) ^ (k >> 3) ^ (k / 5)) & 1);
    endfunction

    // Feeder models: each request presents the next chip's bits one cycle later.
    assign bits_s = (noise & ~MASK_S) | (fbits_s & MASK_S);
    assign bits_d = (noise & ~MASK_D) | (fbits_d & MASK_D);

    int fidx_s, fidx_d;

    always @(posedge clk) begin
        int k;
        logic [15:0] tmp;
        noise <= 16'($urandom);
        if (rst || !en) begin
            fidx_s  <= 0;
            fbits_s <= '0;
        end else if (req_s) begin
            k = (start_s && !busy_s) ? 0 : fidx_s;
            tmp = '0;
            tmp[5]  = (k < 3) ? pat5[k] : 1'b0;
            tmp[15] = (k < 3) ? pat15[k] : 1'b0;
            fbits_s <= tmp;
            fidx_s  <= k + 1;
        end
    end

    always @(posedge clk) begin
        int k;
        logic [15:0] tmp;
        if (rst || !en) begin
            fidx_d  <= 0;
            fbits_d <= '0;
        end else if (req_d) begin
            k = (start_d && !busy_d) ? 0 : fidx_d;
            tmp = '0;
            tmp[9] = pat_big(k);
            fbits_d <= tmp;
            fidx_d  <= k + 1;
        end
    end

    logic signed [15:0] q_s [$];
    logic signed [15:0] q_d [$];
    int cycle = 0;
    int nreq_s = 0, ndone_s = 0, lastv_s = 0, cdone_s = 0;
    int nreq_d = 0, ndone_d = 0;

    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (valid_s) begin
            q_s.push_back(samp_s);
            lastv_s <= cycle;
        end
        if (req_s) nreq_s <= nreq_s + 1;
        if (done_s) begin
            ndone_s <= ndone_s + 1;
            cdone_s <= cycle;
        end
        if (valid_d) q_d.push_back(samp_d);
        if (req_d) nreq_d <= nreq_d + 1;
        if (done_d) ndone_d <= ndone_d + 1;
    end

    task automatic check(input string tag, input int got, input int expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic drive(input bit t, input bit ss, input bit sd);
        @(posedge clk);
        #1;
        trig    = t;
        start_s = ss;
        start_d = sd;
    endtask

    // One small-instance transmission: LOAD cycle has no trigger, then 12 triggers 3 cycles apart.
    task automatic run_small(input logic [3:0] sel, input int restart_at);
        sel_s = sel;
        drive(0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            if (i == restart_at) sel_s = sel ^ 4'hA;
            drive((i % 3 == 1) && (i < 35), i == restart_at, 0);
        end
    endtask

    task automatic check_stream(input string tag, input int n0, input int e [12]);
        check({tag, "_count"}, q_s.size() - n0, 12);
        for (int k = 0; k < 12; k++) begin
            if (n0 + k < q_s.size()) begin
                check($sformatf("%s_s%0d", tag, k), int'(q_s[n0 + k]), e[k]);
            end
        end
    endtask

    initial begin
        int n0, r0, d0, mism, big_n0, big_r0, big_d0;
        rst = 1'b1; en = 1'b1; trig = 1'b0; start_s = 1'b0; start_d = 1'b0;
        sel_s = 4'd5; sel_d = 4'd9;
        drive(0, 0, 0);
        drive(0, 0, 0);
        check("rst_osample", int'(samp_s), 0);
        check("rst_valid", int'(valid_s), 0);
        check("rst_busy", int'(busy_s), 0);
        check("rst_done", int'(done_s), 0);
        check("rst_req", int'(req_s), 0);
        rst = 1'b0;
        drive(0, 0, 0);

        // Reset in the middle of a transmission.
        d0 = ndone_s;
        sel_s = 4'd5;
        drive(0, 1, 0);
        for (int i = 0; i < 10; i++) drive(i % 3 == 1, 0, 0);
        check("midtx_busy", int'(busy_s), 1);
        rst = 1'b1;
        drive(0, 0, 0);
        check("midrst_osample", int'(samp_s), 0);
        check("midrst_valid", int'(valid_s), 0);
        check("midrst_busy", int'(busy_s), 0);
        check("midrst_done", int'(done_s), 0);
        rst = 1'b0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        check("midrst_no_done", ndone_s - d0, 0);

        // Sequence 5 (bits 1,0,1).
        n0 = q_s.size(); r0 = nreq_s; d0 = ndone_s;
        run_small(4'd5, -1);
        check_stream("seq5", n0, exp_a);
        check("seq5_reqs", nreq_s - r0, 3);
        check("seq5_dones", ndone_s - d0, 1);
        check("seq5_done_timing", cdone_s, lastv_s);
        check("seq5_idle_osample", int'(samp_s), 0);
        check("seq5_idle_busy", int'(busy_s), 0);

        // Sequence 15 (bits 0,1,1) with the other feeder bits toggling.
        n0 = q_s.size(); r0 = nreq_s; d0 = ndone_s;
        run_small(4'd15, -1);
        check_stream("seq15", n0, exp_b);
        check("seq15_reqs", nreq_s - r0, 3);
        check("seq15_dones", ndone_s - d0, 1);

        // istart re-pulsed mid-transmission with another selection.
        n0 = q_s.size(); r0 = nreq_s; d0 = ndone_s;
        run_small(4'd5, 5);
        check_stream("restart_ignored", n0, exp_a);
        check("restart_reqs", nreq_s - r0, 3);
        check("restart_dones", ndone_s - d0, 1);

        // Enable dropped right after the 5th sample.
        n0 = q_s.size(); d0 = ndone_s;
        sel_s = 4'd5;
        drive(0, 1, 0);
        for (int i = 0; i < 15; i++) drive((i % 3 == 1) && (i <= 13), 0, 0);
        check("abort_pre_valid", int'(valid_s), 1);
        check("abort_pre_busy", int'(busy_s), 1);
        en = 1'b0;
        drive(0, 0, 0);
        check("abort_osample", int'(samp_s), 0);
        check("abort_valid", int'(valid_s), 0);
        check("abort_busy", int'(busy_s), 0);
        check("abort_partial_count", q_s.size() - n0, 5);
        for (int k = 0; k < 5; k++) begin
            if (n0 + k < q_s.size()) check($sformatf("abort_s%0d", k), int'(q_s[n0 + k]), exp_a[k]);
        end
        for (int i = 0; i < 4; i++) drive(i % 2 == 0, 0, 0);
        check("abort_no_done", ndone_s - d0, 0);
        en = 1'b1;
        drive(0, 0, 0);
        n0 = q_s.size();
        run_small(4'd5, -1);
        check_stream("reenable", n0, exp_a);

        // Defaults: trigger in LOAD, then triggers every 2 cycles.
        big_n0 = q_d.size(); big_r0 = nreq_d; big_d0 = ndone_d;
        sel_d = 4'd9;
        drive(0, 0, 1);
        for (int i = 0; i < 20446; i++) drive((i % 2 == 0) && (i <= 20440), 0, 0);
        check("big_valid_count", q_d.size() - big_n0, 10220);
        check("big_reqs", nreq_d - big_r0, 511);
        check("big_dones", ndone_d - big_d0, 1);
        check("big_idle_busy", int'(busy_d), 0);
        mism = 0;
        for (int n = 0; n < 10220; n++) begin
            int p, lut, e;
            p = n % 4;
            lut = (p == 1) ? 16384 : ((p == 3) ? -16384 : 0);
            e = pat_big(n / 20) ? lut : -lut;
            if (big_n0 + n >= q_d.size() || int'(q_d[big_n0 + n]) != e) mism++;
        end
        check("big_stream_mismatches", mism, 0);
        if (big_n0 < q_d.size()) check("big_first_sample", int'(q_d[big_n0]), 0);
        if (big_n0 + 1 < q_d.size()) check("big_second_sample", int'(q_d[big_n0 + 1]), pat_big(0) ? 16384 : -16384);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_sequence_modulator.md
Name: tx_sequence_modulator

Overview:
Transmit-side counterpart of the receive correlator chain. On a start command it emits one selected binary sequence out of the 16 available ones (index 0..15), one signed 16-bit sample per new-sample trigger. Each chip is BPSK-modulated onto a carrier at fs/4 and lasts SAMPLES_PER_CHIP samples. Chip bits are pulled from the shared sequence-bits feeder, which presents all 16 sequences' current bits in parallel. The output sample stream drives the DAC path.

Parameters:
SEQ_LEN, 511, chips per transmitted sequence (>=2)
SAMPLES_PER_CHIP, 20, samples per chip (>=4, multiple of 4)
AMPLITUDE, 16384, carrier peak magnitude (signed 16-bit, >0)

Ports:
ctx_clk  in  1  clock
rtx_rst  in  1  synchronous reset, active-high
etx_en  in  1  enable; low = synchronous clear, same effect as reset
inew_sample_trig  in  1  one-cycle pulse per output sample period
istart  in  1  one-cycle pulse, begin transmission
iseq_select  in  4  sequence index, sampled with istart
isequences_bits  in  16  current bit of each of the 16 sequences, valid the cycle after onext_bit_req
onext_bit_req  out  1  one-cycle pulse, advance feeder to next chip
osample  out  16 signed  modulated sample, registered, held between triggers
osample_valid  out  1  one-cycle pulse, osample updated this cycle
obusy  out  1  high from LOAD through TX
odone  out  1  one-cycle pulse after the last sample

Behaviour:
- Reset / !etx_en: state IDLE; osample=0, osample_valid=0, onext_bit_req=0, obusy=0, odone=0; all counters, phase and chip registers cleared.
- Carrier LUT, indexed by phase p (2-bit, wraps mod 4): p0 = 0, p1 = +AMPLITUDE, p2 = 0, p3 = -AMPLITUDE.
- Chip value 1 outputs LUT[p]. Chip value 0 outputs -LUT[p].
- IDLE: istart=1 latches iseq_select, pulses onext_bit_req, moves to LOAD. istart is ignored in every other state.
- LOAD (exactly 1 cycle):
  - rchip <= isequences_bits[sel].
  - Pulse onext_bit_req to prefetch chip 1.
  - Move to TX with sample_cnt=0, chip_cnt=0, p=0.
  - A trigger arriving in LOAD is dropped; no sample is emitted.
- Prefetch: every cycle following an onext_bit_req issued in LOAD or TX, rchip_next <= isequences_bits[sel].
- TX, on each inew_sample_trig (output registered, available the cycle after the trigger):
  - osample <= modulated value of rchip at phase p; osample_valid=1; p <= p+1.
  - If sample_cnt < SAMPLES_PER_CHIP-1: sample_cnt++.
  - Else if chip_cnt < SEQ_LEN-1:
    - sample_cnt <= 0; chip_cnt++; rchip <= rchip_next.
    - Pulse onext_bit_req, unless the new chip_cnt == SEQ_LEN-1 (no fetch beyond the sequence).
  - Else (last sample of the last chip): move to DONE.
- DONE (1 cycle): odone=1; osample <= 0; move to IDLE.
- osample holds its value between triggers. It is 0 whenever not in TX.
- Phase is continuous across chip boundaries. The carrier starts at p0 for chip 0.
- Total per transmission: exactly SEQ_LEN*SAMPLES_PER_CHIP osample_valid pulses and SEQ_LEN onext_bit_req pulses.
- Trigger spacing must be >=2 cycles, so a prefetch always completes before the next chip boundary.
- etx_en low or reset mid-transmission aborts immediately:
  - no odone pulse;
  - the feeder is not rewound here; the feeder shares etx_en and clears itself.
- obusy=1 in LOAD and TX, 0 in IDLE and DONE.
- Counter widths: clog2(SEQ_LEN) and clog2(SAMPLES_PER_CHIP). Negation of AMPLITUDE cannot overflow because AMPLITUDE < 32768.

Test Plan:
1. Reset mid-TX, then idle -> osample=0, osample_valid=0, obusy=0, odone=0; the next istart behaves normally.
2. SEQ_LEN=3, SAMPLES_PER_CHIP=4, AMPLITUDE=100, iseq_select=5, feeder bit5 sequence 1,0,1, trigger every 3 cycles -> osample sequence 0,100,0,-100, 0,-100,0,100, 0,100,0,-100; 12 valid pulses; 3 onext_bit_req pulses; odone 1 cycle after the 12th sample.
3. Same parameters, iseq_select=15, feeder bits of other sequences toggling randomly -> output depends only on bit15.
4. istart re-pulsed during TX with a different iseq_select -> ignored; the output stream is unchanged.
5. etx_en dropped after the 5th sample -> next cycle IDLE, osample=0, no odone; after re-enable, istart restarts at chip 0, phase 0.
6. Trigger pulse in the LOAD cycle, then minimum trigger spacing of 2 cycles at defaults -> no sample for the LOAD trigger; 10220 valid pulses; every chip boundary uses the correctly prefetched bit.
